uart_fifo_bridge: RTL and testbench

UART_FIFO_BRIDGE -- requirements
Module: uart_fifo_bridge

---
 rtl/uart_fifo_bridge.sv | 176 +++++++++++++++++
 tb/tb_uart_fifo_bridge.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_bridge.sv
// CPU-side register bridge to a byte UART core: TX and RX byte FIFOs, small
// handshake FSMs toward the core, a status register with sticky error flags.
module uart_fifo_bridge #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       sys_clk_i,
  input  logic       sys_rst_i,
  input  logic [1:0] io_addr_i,
  input  logic       io_wr_i,
  input  logic       io_rd_i,
  input  logic [7:0] io_dat_i,
  output logic [7:0] io_dat_o,
  output logic       irq_o,
  output logic       uart_wr_o,
  output logic [7:0] uart_dat_o,
  input  logic       uart_busy_i,
  input  logic       uart_valid_i,
  input  logic [7:0] uart_dat_i,
  output logic       uart_rd_o
);

  typedef enum logic [1:0] {TX_IDLE, TX_STROBE, TX_ACK, TX_DRAIN} tx_state_t;
  typedef enum logic {RX_IDLE, RX_HOLD} rx_state_t;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic [AW:0]   tx_cnt, rx_cnt;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic          rx_stall, tx_drop, tx_idle;
  logic          status_rd, stall_set, drop_set;
  logic [1:0]    ack_cnt;
  logic [7:0]    rd_mux;
  tx_state_t     tx_state, tx_next;
  rx_state_t     rx_state, rx_next;

  assign tx_full  = (tx_cnt == FULL_CNT);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);

  assign tx_push   = io_wr_i && (io_addr_i == 2'd0) && !tx_full;
  assign drop_set  = io_wr_i && (io_addr_i == 2'd0) && tx_full;
  assign rx_pop    = io_rd_i && (io_addr_i == 2'd0) && !rx_empty;
  assign status_rd = io_rd_i && (io_addr_i == 2'd1);
  assign tx_idle   = tx_empty && (tx_state == TX_IDLE) && !uart_busy_i;

  // Only an actual capture attempt counts as a stall; in HOLD the byte is already taken.
  assign rx_push   = (rx_state == RX_IDLE) && uart_valid_i && !rx_full;
  assign stall_set = (rx_state == RX_IDLE) && uart_valid_i && rx_full;

  // FIFO storage carries no reset; pointers and counts define its contents.
  always_ff @(posedge sys_clk_i) begin
    if (tx_push) tx_mem[tx_wptr] <= io_dat_i;
    if (rx_push) rx_mem[rx_wptr] <= uart_dat_i;
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_cnt  <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_cnt  <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PTR_ONE;
      if (tx_pop)  tx_rptr <= tx_rptr + PTR_ONE;
      if (rx_push) rx_wptr <= rx_wptr + PTR_ONE;
      if (rx_pop)  rx_rptr <= rx_rptr + PTR_ONE;
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CNT_ONE;
        2'b01:   tx_cnt <= tx_cnt - CNT_ONE;
        default: tx_cnt <= tx_cnt;
      endcase
      unique case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + CNT_ONE;
        2'b01:   rx_cnt <= rx_cnt - CNT_ONE;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // TX handshake: the pop happens on the edge entering STROBE so uart_dat_o is
  // valid for the whole strobe cycle and then simply holds.
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (!tx_empty && !uart_busy_i) begin
          tx_next = TX_STROBE;
          tx_pop  = 1'b1;
        end
      end
      TX_STROBE: tx_next = TX_ACK;
      TX_ACK:    if (uart_busy_i || (ack_cnt == 2'd3)) tx_next = TX_DRAIN;
      TX_DRAIN:  if (!uart_busy_i) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      tx_state   <= TX_IDLE;
      ack_cnt    <= 2'd0;
      uart_wr_o  <= 1'b0;
      uart_dat_o <= 8'h00;
    end else begin
      tx_state  <= tx_next;
      ack_cnt   <= (tx_state == TX_ACK) ? ack_cnt + 2'd1 : 2'd0;
      uart_wr_o <= tx_pop;
      if (tx_pop) uart_dat_o <= tx_mem[tx_rptr];
    end
  end

  always_comb begin
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE: if (rx_push) rx_next = RX_HOLD;
      RX_HOLD: rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      rx_state  <= RX_IDLE;
      uart_rd_o <= 1'b0;
    end else begin
      rx_state  <= rx_next;
      uart_rd_o <= rx_push;
    end
  end

  // Sticky flags: a set event in the clearing cycle takes priority.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      rx_stall <= 1'b0;
      tx_drop  <= 1'b0;
    end else begin
      if (stall_set)      rx_stall <= 1'b1;
      else if (status_rd) rx_stall <= 1'b0;
      if (drop_set)       tx_drop  <= 1'b1;
      else if (status_rd) tx_drop  <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = 8'h00;
    unique case (io_addr_i)
      2'd0:    rd_mux = rx_empty ? 8'h00 : rx_mem[rx_rptr];
      2'd1:    rd_mux = {2'b00, tx_drop, rx_stall, rx_full, tx_idle, !tx_full, !rx_empty};
      2'd2:    rd_mux = 8'(rx_cnt);
      2'd3:    rd_mux = 8'(tx_cnt);
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      io_dat_o <= 8'h00;
      irq_o    <= 1'b0;
    end else begin
      if (io_rd_i) io_dat_o <= rd_mux;
      irq_o <= !rx_empty;
    end
  end

endmodule

// File: tb/tb_uart_fifo_bridge.sv
// Bench for uart_fifo_bridge: directed CPU/UART stimulus with a queue-based
// scoreboard checking CPU read data and bytes strobed to the UART core.
`timescale 1ns/1ps
module tb_uart_fifo_bridge;

  logic       sys_clk_i = 1'b0;
  logic       sys_rst_i = 1'b0;
  logic [1:0] io_addr_i = 2'd0;
  logic       io_wr_i = 1'b0;
  logic       io_rd_i = 1'b0;
  logic [7:0] io_dat_i = 8'h00;
  logic [7:0] io_dat_o;
  logic       irq_o;
  logic       uart_wr_o;
  logic [7:0] uart_dat_o;
  logic       uart_busy_i;
  logic       uart_valid_i = 1'b0;
  logic [7:0] uart_dat_i = 8'h00;
  logic       uart_rd_o;

  int         busy_cnt = 0;
  logic       busy_force = 1'b0;
  logic       rx_load = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rd_q = 1'b0;
  int         rd_pulses = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  logic [7:0] exp_rd_q[$];
  string      exp_rd_name[$];
  logic [7:0] exp_tx_q[$];

  always #5 sys_clk_i = ~sys_clk_i;

  uart_fifo_bridge #(.DEPTH(16), .AW(4)) dut (
    .sys_clk_i   (sys_clk_i),
    .sys_rst_i   (sys_rst_i),
    .io_addr_i   (io_addr_i),
    .io_wr_i     (io_wr_i),
    .io_rd_i     (io_rd_i),
    .io_dat_i    (io_dat_i),
    .io_dat_o    (io_dat_o),
    .irq_o       (irq_o),
    .uart_wr_o   (uart_wr_o),
    .uart_dat_o  (uart_dat_o),
    .uart_busy_i (uart_busy_i),
    .uart_valid_i(uart_valid_i),
    .uart_dat_i  (uart_dat_i),
    .uart_rd_o   (uart_rd_o)
  );

  // UART core model: 20 busy cycles per strobed byte; RX byte held until acked.
  assign uart_busy_i = busy_force || (busy_cnt != 0);

  always @(posedge sys_clk_i) begin
    if (uart_wr_o) busy_cnt <= 20;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (rx_load) begin
      uart_valid_i <= 1'b1;
      uart_dat_i   <= rx_byte;
    end else if (uart_rd_o) begin
      uart_valid_i <= 1'b0;
    end
    rd_q <= io_rd_i;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  task automatic unexpected(input string nm, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: actual 0x%0h with nothing expected", nm, act);
  endtask

  // Monitor: pops expectations whenever the DUT presents read data or a TX strobe.
  always @(negedge sys_clk_i) begin
    if (uart_rd_o) rd_pulses <= rd_pulses + 1;
    if (rd_q) begin
      if (exp_rd_q.size() == 0) unexpected("rd_data", io_dat_o);
      else check(exp_rd_name.pop_front(), io_dat_o, exp_rd_q.pop_front());
    end
    if (uart_wr_o) begin
      check("tx_busy_low", uart_busy_i, 0);
      if (exp_tx_q.size() == 0) unexpected("tx_byte", uart_dat_o);
      else check("tx_byte", uart_dat_o, exp_tx_q.pop_front());
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk_i);
    #1;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] d);
    @(posedge sys_clk_i); #1;
    io_addr_i = a; io_dat_i = d; io_wr_i = 1'b1;
    @(posedge sys_clk_i); #1;
    io_wr_i = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, input logic [7:0] e, input string nm);
    @(posedge sys_clk_i); #1;
    io_addr_i = a; io_rd_i = 1'b1;
    exp_rd_q.push_back(e);
    exp_rd_name.push_back(nm);
    @(posedge sys_clk_i); #1;
    io_rd_i = 1'b0;
  endtask

  task automatic tx_send(input logic [7:0] d);
    cpu_wr(2'd0, d);
    exp_tx_q.push_back(d);
  endtask

  task automatic rx_send(input logic [7:0] b);
    int p;
    int k;
    p = rd_pulses;
    @(posedge sys_clk_i); #1;
    rx_byte = b; rx_load = 1'b1;
    @(posedge sys_clk_i); #1;
    rx_load = 1'b0;
    k = 0;
    while (rd_pulses == p && k < 20) begin
      @(posedge sys_clk_i);
      k++;
    end
    check("rx_ack_pulse", rd_pulses, p + 1);
    cycles(2);
  endtask

  task automatic wait_tx_drain(input int limit);
    int k;
    k = 0;
    while (exp_tx_q.size() != 0 && k < limit) begin
      @(posedge sys_clk_i);
      k++;
    end
    check("tx_drain_left", exp_tx_q.size(), 0);
    cycles(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    #1 sys_rst_i = 1'b1;
    #3;
    check("rst_io_dat", io_dat_o, 8'h00);
    check("rst_uart_dat", uart_dat_o, 8'h00);
    check("rst_uart_wr", uart_wr_o, 0);
    check("rst_uart_rd", uart_rd_o, 0);
    check("rst_irq", irq_o, 0);
    cycles(3);
    sys_rst_i = 1'b0;
    cycles(2);
    cpu_rd(2'd1, 8'h06, "status_after_reset");
    cpu_rd(2'd2, 8'h00, "rxcnt_reset");
    cpu_rd(2'd3, 8'h00, "txcnt_reset");

    // Three bytes out through a busy core, strictly in order.
    tx_send(8'h41);
    tx_send(8'h42);
    tx_send(8'h43);
    wait_tx_drain(200);
    cycles(30);

    // Single received byte, interrupt follows RX occupancy.
    rx_send(8'h55);
    cpu_rd(2'd2, 8'h01, "rxcnt_one");
    check("irq_high", irq_o, 1);
    cpu_rd(2'd0, 8'h55, "rx_data_55");
    cycles(2);
    check("irq_low", irq_o, 0);

    // TX overflow while the core stays busy.
    busy_force = 1'b1;
    for (int i = 0; i < 16; i++) tx_send(8'hA0 + 8'(i));
    cpu_wr(2'd0, 8'hEE);
    cpu_rd(2'd1, 8'h20, "status_drop");
    cpu_rd(2'd3, 8'h10, "txcnt_full");
    cpu_rd(2'd1, 8'h00, "status_drop_cleared");
    busy_force = 1'b0;
    wait_tx_drain(1500);
    cycles(30);

    // Empty RX read, then simultaneous push/pop on both FIFOs.
    cpu_rd(2'd0, 8'h00, "rx_empty_read");
    cpu_rd(2'd2, 8'h00, "rxcnt_empty");
    busy_force = 1'b1;
    tx_send(8'h31);
    @(posedge sys_clk_i); #1;
    busy_force = 1'b0;
    io_addr_i = 2'd0; io_dat_i = 8'h32; io_wr_i = 1'b1;
    exp_tx_q.push_back(8'h32);
    @(posedge sys_clk_i); #1;
    io_wr_i = 1'b0;
    cpu_rd(2'd3, 8'h01, "txcnt_push_pop");
    wait_tx_drain(200);
    cycles(30);

    for (int i = 1; i <= 5; i++) rx_send(8'(i));
    cpu_rd(2'd2, 8'h05, "rxcnt_five");
    @(posedge sys_clk_i); #1;
    rx_byte = 8'h06; rx_load = 1'b1;
    @(posedge sys_clk_i); #1;
    rx_load = 1'b0;
    io_addr_i = 2'd0; io_rd_i = 1'b1;
    exp_rd_q.push_back(8'h01);
    exp_rd_name.push_back("rx_pop_during_push");
    @(posedge sys_clk_i); #1;
    io_rd_i = 1'b0;
    cycles(3);
    cpu_rd(2'd2, 8'h05, "rxcnt_push_pop");
    for (int i = 2; i <= 6; i++) cpu_rd(2'd0, 8'(i), "rx_drain_small");
    cpu_rd(2'd1, 8'h06, "status_idle");

    // RX full: the core must keep its byte until space appears.
    for (int i = 0; i < 16; i++) rx_send(8'h80 + 8'(i));
    cpu_rd(2'd2, 8'h10, "rxcnt_full");
    p = rd_pulses;
    @(posedge sys_clk_i); #1;
    rx_byte = 8'h99; rx_load = 1'b1;
    @(posedge sys_clk_i); #1;
    rx_load = 1'b0;
    cycles(6);
    check("rx_no_ack_full", rd_pulses, p);
    cpu_rd(2'd1, 8'h1F, "status_rx_full");
    cpu_rd(2'd0, 8'h80, "rx_full_head");
    cycles(4);
    check("rx_ack_after_pop", rd_pulses, p + 1);
    cpu_rd(2'd2, 8'h10, "rxcnt_refill");
    for (int i = 1; i < 16; i++) cpu_rd(2'd0, 8'h80 + 8'(i), "rx_drain_full");
    cpu_rd(2'd0, 8'h99, "rx_stalled_byte");
    cpu_rd(2'd1, 8'h16, "status_stall_sticky");
    cpu_rd(2'd1, 8'h06, "status_stall_cleared");

    // Reset while draining with bytes still queued.
    rx_send(8'h5A);
    tx_send(8'h11);
    cpu_wr(2'd0, 8'h12);
    cpu_wr(2'd0, 8'h13);
    cpu_wr(2'd0, 8'h14);
    cpu_rd(2'd3, 8'h03, "txcnt_before_reset");
    check("irq_before_reset", irq_o, 1);
    @(posedge sys_clk_i); #1;
    sys_rst_i = 1'b1;
    #2;
    check("midrst_io_dat", io_dat_o, 8'h00);
    check("midrst_uart_dat", uart_dat_o, 8'h00);
    check("midrst_uart_wr", uart_wr_o, 0);
    check("midrst_uart_rd", uart_rd_o, 0);
    check("midrst_irq", irq_o, 0);
    cycles(2);
    sys_rst_i = 1'b0;
    cycles(30);
    cpu_rd(2'd1, 8'h06, "status_after_midreset");
    cpu_rd(2'd2, 8'h00, "rxcnt_after_midreset");
    cpu_rd(2'd3, 8'h00, "txcnt_after_midreset");
    tx_send(8'h77);
    wait_tx_drain(200);
    cycles(5);
    check("rd_queue_left", exp_rd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
